// File: rtl/cpu_div_pkg.sv
// Shared types and constants for the iterative A-stage divider.
package cpu_div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    // Quotient returned for any divide by zero, signed or unsigned.
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREP,
        ST_ITER,
        ST_FIX
    } div_state_e;

endpackage

// File: rtl/cpu_div_step.sv
// One radix-2 restoring division step: shift a dividend bit into the
// partial remainder and trial-subtract the divisor.
module cpu_div_step
    import cpu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dvd_msb_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] shifted;

    // Trial subtract; the partial remainder is always below the divisor, so
    // a successful difference fits back into WIDTH bits.
    always_comb begin
        // NOTE: combinational blocks use blocking '=' so later lines see the
        // values computed by earlier ones within the same evaluation.
        shifted = {rem_i, dvd_msb_i};
        if (shifted >= {1'b0, dvs_i}) begin
            rem_o   = shifted[WIDTH-1:0] - dvs_i;
            q_bit_o = 1'b1;
        end else begin
            rem_o   = shifted[WIDTH-1:0];
            q_bit_o = 1'b0;
        end
    end

endmodule

// File: rtl/cpu_div_cell.sv
// Iterative 32-bit div/divu for the A-stage: one quotient bit per clock,
// results and a one-cycle done pulse WIDTH+2 cycles after the start edge.
module cpu_div_cell
    import cpu_div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             A_div_start,
    input  logic             A_div_signed,
    input  logic [WIDTH-1:0] A_div_src1,
    input  logic [WIDTH-1:0] A_div_src2,
    output logic [WIDTH-1:0] A_div_quot_result,
    output logic [WIDTH-1:0] A_div_rem_result,
    output logic             A_div_done,
    output logic             A_div_busy
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ZERO_QUOT = {WIDTH{DIV_ZERO_QUOT[0]}};

    div_state_e       state_q, state_d;
    logic [WIDTH-1:0] src1_q, src1_d;       // raw dividend, also the div-by-zero remainder
    logic [WIDTH-1:0] src2_q, src2_d;
    logic             signed_q, signed_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;         // |dividend|, becomes the quotient as bits shift in
    logic [WIDTH-1:0] dvs_q, dvs_d;         // |divisor|
    logic [WIDTH-1:0] rem_q, rem_d;         // partial remainder
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] quot_res_q, quot_res_d;
    logic [WIDTH-1:0] rem_res_q, rem_res_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             neg1, neg2;
    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;

    cpu_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .dvd_msb_i (dvd_q[WIDTH-1]),
        .dvs_i     (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_qbit)
    );

    // Next-state and datapath updates for the IDLE/PREP/ITER/FIX sequence.
    always_comb begin
        // NOTE: every output of this block is defaulted first so no path
        // leaves a signal unassigned, which would infer a latch.
        state_d    = state_q;
        src1_d     = src1_q;
        src2_d     = src2_q;
        signed_d   = signed_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        quot_res_d = quot_res_q;
        rem_res_d  = rem_res_q;
        done_d     = 1'b0;
        busy_d     = busy_q;

        neg1 = signed_q & src1_q[WIDTH-1];
        neg2 = signed_q & src2_q[WIDTH-1];

        unique case (state_q)
            ST_IDLE: begin
                if (A_div_start) begin
                    src1_d   = A_div_src1;
                    src2_d   = A_div_src2;
                    signed_d = A_div_signed;
                    busy_d   = 1'b1;
                    state_d  = ST_PREP;
                end
            end
            ST_PREP: begin
                dvd_d      = neg1 ? -src1_q : src1_q;
                dvs_d      = neg2 ? -src2_q : src2_q;
                neg_quot_d = neg1 ^ neg2;
                neg_rem_d  = neg1;
                div_zero_d = (src2_q == '0);
                rem_d      = '0;
                cnt_d      = CNT_W'(WIDTH - 1);
                state_d    = ST_ITER;
            end
            ST_ITER: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[WIDTH-2:0], step_qbit};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                // Divide by zero overrides sign correction; 0x80000000 / -1
                // needs nothing special since the negate wraps.
                if (div_zero_q) begin
                    quot_res_d = ZERO_QUOT;
                    rem_res_d  = src1_q;
                end else begin
                    quot_res_d = neg_quot_q ? -dvd_q : dvd_q;
                    rem_res_d  = neg_rem_q  ? -rem_q : rem_q;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset discards any operation in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: this is a handful of flops, not a memory array, so every
        // register is reset to a known value.
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            src1_q     <= '0;
            src2_q     <= '0;
            signed_q   <= 1'b0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            quot_res_q <= '0;
            rem_res_q  <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking '<=' so all flops
            // update together from the values held before the edge.
            state_q    <= state_d;
            src1_q     <= src1_d;
            src2_q     <= src2_d;
            signed_q   <= signed_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            quot_res_q <= quot_res_d;
            rem_res_q  <= rem_res_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign A_div_quot_result = quot_res_q;
    assign A_div_rem_result  = rem_res_q;
    assign A_div_done        = done_q;
    assign A_div_busy        = busy_q;

endmodule

// File: tb/tb_cpu_div_cell.sv
// Self-checking bench for cpu_div_cell: directed cases, random operands
// against an arithmetic reference, handshake and reset scenarios.
module tb_cpu_div_cell;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic         sgn;
    logic [W-1:0] s1, s2;
    logic [W-1:0] q, r;
    logic         done, busy;

    int total = 0;
    int bad   = 0;

    cpu_div_cell #(.WIDTH(W)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .A_div_start       (start),
        .A_div_signed      (sgn),
        .A_div_src1        (s1),
        .A_div_src2        (s2),
        .A_div_quot_result (q),
        .A_div_rem_result  (r),
        .A_div_done        (done),
        .A_div_busy        (busy)
    );

    always #5 clk = ~clk;

    // Reference: plain integer division with truncation toward zero.
    function automatic void ref_div(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] eq, output logic [W-1:0] er);
        longint sa, sb;
        if (b == '0) begin
            eq = '1;
            er = a;
        end else if (sg) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            eq = W'(sa / sb);
            er = W'(sa % sb);
        end else begin
            eq = a / b;
            er = a % b;
        end
    endfunction

    // Issue one operation from just after a rising edge and wait for done.
    task automatic run_op(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] gq, output logic [W-1:0] gr,
                          output int lat, output int busy_errs);
        start = 1'b1;
        sgn   = sg;
        s1    = a;
        s2    = b;
        @(posedge clk); #1;
        start = 1'b0;
        sgn   = ~sg;
        s1    = $urandom;
        s2    = $urandom;
        lat       = -1;
        busy_errs = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                if (busy) busy_errs++;
                break;
            end
            if (!busy) busy_errs++;
        end
        gq = q;
        gr = r;
    endtask

    task automatic test_reset();
        #1;
        total++; if (q !== '0)   begin bad++; $display("FAIL reset_quot got=%h want=0", q); end
        total++; if (r !== '0)   begin bad++; $display("FAIL reset_rem got=%h want=0", r); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        total++; if ({done, busy} !== 2'b00) begin bad++; $display("FAIL post_reset_idle got=%b want=00", {done, busy}); end
    endtask

    task automatic test_directed();
        logic         v_sg [8] = '{0, 1, 1, 1, 0, 0, 1, 1};
        logic [W-1:0] v_a  [8] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000,
                                   32'hFFFF_FFFF, 32'h1234, 32'h1234, 32'hFFFF_FF00};
        logic [W-1:0] v_b  [8] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                   32'd1, 32'd0, 32'd0, 32'd0};
        logic [W-1:0] v_q  [8] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000,
                                   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [W-1:0] v_r  [8] = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'd0,
                                   32'd0, 32'h1234, 32'h1234, 32'hFFFF_FF00};
        logic [W-1:0] gq, gr;
        int lat, be;
        for (int i = 0; i < 8; i++) begin
            run_op(v_sg[i], v_a[i], v_b[i], gq, gr, lat, be);
            total++; if (gq !== v_q[i]) begin bad++; $display("FAIL directed%0d_quot got=%h want=%h", i, gq, v_q[i]); end
            total++; if (gr !== v_r[i]) begin bad++; $display("FAIL directed%0d_rem got=%h want=%h", i, gr, v_r[i]); end
            total++; if (lat !== LAT)   begin bad++; $display("FAIL directed%0d_latency got=%0d want=%0d", i, lat, LAT); end
            total++; if (be !== 0)      begin bad++; $display("FAIL directed%0d_busy got=%0d_errors want=0", i, be); end
            @(posedge clk); #1;
            total++; if (done !== 1'b0) begin bad++; $display("FAIL directed%0d_done_pulse got=%b want=0", i, done); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, eq, er, gq, gr;
        logic sg;
        int lat, be;
        for (int i = 0; i < 40; i++) begin
            sg = 1'($urandom);
            a  = $urandom;
            case ($urandom_range(0, 4))
                0:       b = $urandom;
                1:       b = W'($urandom_range(1, 15));
                2:       b = -W'($urandom_range(1, 15));
                3:       b = $urandom >> $urandom_range(0, 31);
                default: b = (i % 10 == 0) ? '0 : $urandom >> 16;
            endcase
            ref_div(sg, a, b, eq, er);
            run_op(sg, a, b, gq, gr, lat, be);
            total++; if ({gq, gr} !== {eq, er}) begin
                bad++;
                $display("FAIL random%0d sg=%b a=%h b=%h got q=%h r=%h want q=%h r=%h", i, sg, a, b, gq, gr, eq, er);
            end
            total++; if (lat !== LAT || be !== 0) begin
                bad++;
                $display("FAIL random%0d_timing got lat=%0d busy_errs=%0d want lat=%0d busy_errs=0", i, lat, be, LAT);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] xq, xr, aq, ar, gq, gr;
        int lat, be, held_errs, seen_done, extra_done;
        ref_div(1'b0, 32'd1000, 32'd9, xq, xr);
        run_op(1'b0, 32'd1000, 32'd9, gq, gr, lat, be);
        total++; if ({gq, gr} !== {xq, xr}) begin bad++; $display("FAIL ignore_prior got=%h/%h want=%h/%h", gq, gr, xq, xr); end
        @(posedge clk); #1;
        ref_div(1'b1, 32'hFFFF_F000, 32'd37, aq, ar);
        start = 1'b1; sgn = 1'b1; s1 = 32'hFFFF_F000; s2 = 32'd37;
        @(posedge clk); #1;
        start = 1'b0;
        held_errs = 0;
        seen_done = 0;
        for (int n = 1; n <= 60; n++) begin
            if (n == 9) begin
                start = 1'b1; sgn = 1'b0; s1 = 32'd55; s2 = 32'd5;
            end
            @(posedge clk); #1;
            if (n == 9) start = 1'b0;
            if (done) begin
                seen_done = n;
                break;
            end
            if ({q, r} !== {xq, xr}) held_errs++;
        end
        total++; if (held_errs !== 0)  begin bad++; $display("FAIL ignore_hold got=%0d_changes want=0", held_errs); end
        total++; if (seen_done !== LAT) begin bad++; $display("FAIL ignore_latency got=%0d want=%0d", seen_done, LAT); end
        total++; if ({q, r} !== {aq, ar}) begin bad++; $display("FAIL ignore_result got=%h/%h want=%h/%h", q, r, aq, ar); end
        extra_done = 0;
        for (int n = 0; n < 45; n++) begin
            @(posedge clk); #1;
            if (done) extra_done++;
        end
        total++; if (extra_done !== 0) begin bad++; $display("FAIL ignore_not_queued got=%0d_dones want=0", extra_done); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] eq, er, gq, gr;
        int lat, be;
        ref_div(1'b1, 32'hFFFF_FF9C, 32'd7, eq, er);
        run_op(1'b1, 32'hFFFF_FF9C, 32'd7, gq, gr, lat, be);
        total++; if ({gq, gr} !== {eq, er}) begin bad++; $display("FAIL b2b_first got=%h/%h want=%h/%h", gq, gr, eq, er); end
        // run_op returns in the done cycle, so this start coincides with done.
        ref_div(1'b0, 32'hDEAD_BEEF, 32'h0001_0001, eq, er);
        run_op(1'b0, 32'hDEAD_BEEF, 32'h0001_0001, gq, gr, lat, be);
        total++; if ({gq, gr} !== {eq, er}) begin bad++; $display("FAIL b2b_second got=%h/%h want=%h/%h", gq, gr, eq, er); end
        total++; if (lat !== LAT || be !== 0) begin
            bad++; $display("FAIL b2b_timing got lat=%0d busy_errs=%0d want lat=%0d busy_errs=0", lat, be, LAT);
        end
    endtask

    task automatic test_reset_midop();
        logic [W-1:0] eq, er, gq, gr;
        int lat, be, dones;
        start = 1'b1; sgn = 1'b0; s1 = 32'd12345; s2 = 32'd11;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk); #1;
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++; if ({q, r} !== '0) begin bad++; $display("FAIL midreset_results got=%h/%h want=0/0", q, r); end
        total++; if ({done, busy} !== 2'b00) begin bad++; $display("FAIL midreset_flags got=%b want=00", {done, busy}); end
        @(negedge clk);
        reset_n = 1'b1;
        dones = 0;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        total++; if (dones !== 0) begin bad++; $display("FAIL midreset_discard got=%0d_active_cycles want=0", dones); end
        ref_div(1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFD, eq, er);
        run_op(1'b1, 32'h7FFF_FFFF, 32'hFFFF_FFFD, gq, gr, lat, be);
        total++; if ({gq, gr} !== {eq, er}) begin bad++; $display("FAIL midreset_recover got=%h/%h want=%h/%h", gq, gr, eq, er); end
        total++; if (lat !== LAT) begin bad++; $display("FAIL midreset_latency got=%0d want=%0d", lat, LAT); end
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        sgn     = 1'b0;
        s1      = '0;
        s2      = '0;
        #3;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
